// File: rtl/aes_pkg.sv
// Shared AES key-handling types used by the key schedule arbiter and its helpers.
package aes_pkg;

    localparam int AES_KEY_W = 128;

    typedef logic [AES_KEY_W-1:0] aes_key_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_GRANT  = 2'd3
    } key_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int c;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/key_sched_arbiter.sv
// Shares one key-expansion engine among NUM_REQ cores, skipping the engine when
// the requested key matches the last expanded one.
module key_sched_arbiter
    import aes_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int WAIT_MAX = 63
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ*AES_KEY_W-1:0] req_key_i,
    input  logic [NUM_REQ-1:0]           hold_i,
    input  logic                         flush_i,
    output logic [NUM_REQ-1:0]           grant_o,
    output logic                         grant_hit_o,
    output logic                         eng_valid_o,
    input  logic                         eng_ready_i,
    output logic [AES_KEY_W-1:0]         eng_key_o,
    input  logic                         eng_done_i,
    output logic                         busy_o,
    output logic                         err_timeout_o
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX);

    key_arb_state_e state, state_nxt;

    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      win_idx;
    logic               hit_reg;
    aes_key_t           lat_key;
    logic               cache_valid;
    aes_key_t           cached_key;
    logic [CW-1:0]      wait_cnt;
    logic               err_q;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    aes_key_t           win_key;
    logic               hit_now;

    logic               launch_go;
    logic               hit_go;
    logic               done_ok;
    logic               timeout;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req (req_valid_i),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // One-hot AND-OR select of the winning core's key.
    always_comb begin
        win_key = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i])
                win_key = win_key | req_key_i[i*AES_KEY_W +: AES_KEY_W];
        end
    end

    assign hit_now = cache_valid && (win_key == cached_key);

    always_comb begin
        state_nxt = state;
        launch_go = 1'b0;
        hit_go    = 1'b0;
        done_ok   = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                if (arb_any) begin
                    if (hit_now) begin
                        hit_go    = 1'b1;
                        state_nxt = S_GRANT;
                    end else if (hold_i == '0) begin
                        launch_go = 1'b1;
                        state_nxt = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                if (eng_ready_i)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done_i) begin
                    done_ok   = 1'b1;
                    state_nxt = S_GRANT;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_GRANT: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            win_idx  <= '0;
            hit_reg  <= 1'b0;
            lat_key  <= '0;
            wait_cnt <= '0;
            rr_ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (launch_go || hit_go) begin
                win_idx <= arb_idx;
                hit_reg <= hit_go;
            end
            if (launch_go)
                lat_key <= win_key;
            if (state == S_LAUNCH && eng_ready_i)
                wait_cnt <= '0;
            else if (state == S_WAIT)
                wait_cnt <= wait_cnt + 1'b1;
            if (state == S_GRANT)
                rr_ptr <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    // Flush outranks both the done fill and the timeout flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_valid <= 1'b0;
            cached_key  <= '0;
            err_q       <= 1'b0;
        end else begin
            if (done_ok)
                cached_key <= lat_key;
            if (flush_i)
                cache_valid <= 1'b0;
            else if (done_ok)
                cache_valid <= 1'b1;
            else if (timeout)
                cache_valid <= 1'b0;
            if (flush_i)
                err_q <= 1'b0;
            else if (timeout)
                err_q <= 1'b1;
        end
    end

    assign eng_valid_o   = (state == S_LAUNCH);
    assign eng_key_o     = eng_valid_o ? lat_key : '0;
    assign busy_o        = (state != S_IDLE);
    assign grant_o       = (state == S_GRANT) ? (NUM_REQ'(1) << win_idx) : '0;
    assign grant_hit_o   = (state == S_GRANT) && hit_reg;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_key_sched_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grant order, hit flags
// and engine launch keys; a monitor compares them against the DUT.
module tb_key_sched_arbiter;
    import aes_pkg::*;

    localparam int N  = 3;
    localparam int WM = 63;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_valid_i;
    logic [N*128-1:0]     req_key_i;
    logic [N-1:0]         hold_i;
    logic                 flush_i;
    logic [N-1:0]         grant_o;
    logic                 grant_hit_o;
    logic                 eng_valid_o;
    logic                 eng_ready_i;
    logic [127:0]         eng_key_o;
    logic                 eng_done_i;
    logic                 busy_o;
    logic                 err_timeout_o;

    always #5 clk = ~clk;

    key_sched_arbiter #(.NUM_REQ(N), .WAIT_MAX(WM)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_key_i     (req_key_i),
        .hold_i        (hold_i),
        .flush_i       (flush_i),
        .grant_o       (grant_o),
        .grant_hit_o   (grant_hit_o),
        .eng_valid_o   (eng_valid_o),
        .eng_ready_i   (eng_ready_i),
        .eng_key_o     (eng_key_o),
        .eng_done_i    (eng_done_i),
        .busy_o        (busy_o),
        .err_timeout_o (err_timeout_o)
    );

    typedef struct {
        int core;
        bit hit;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int unsigned hs_cyc = 0;
    exp_t        exp_grant[$];
    aes_key_t    exp_launch[$];
    bit          m_cv;
    aes_key_t    m_ck;
    int          m_ptr;
    aes_key_t    core_key[N];
    logic [N-1:0] pend;
    int          eng_delay;
    bit          ready_force;
    bit          hold_rand;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic aes_key_t rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Serve every pending core in round-robin order; a miss costs one engine run.
    task automatic model_batch(input logic [N-1:0] mask);
        logic [N-1:0] p;
        int w;
        bit h;
        p = mask;
        while (p != '0) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && p[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            h = m_cv && (core_key[w] == m_ck);
            if (!h) begin
                exp_launch.push_back(core_key[w]);
                m_ck = core_key[w];
                m_cv = 1'b1;
            end
            exp_grant.push_back('{core: w, hit: h});
            m_ptr = (w + 1) % N;
            p[w] = 1'b0;
        end
    endtask

    task automatic start_batch(input logic [N-1:0] mask);
        model_batch(mask);
        for (int i = 0; i < N; i++)
            if (mask[i]) req_key_i[i*128 +: 128] = core_key[i];
        req_valid_i = req_valid_i | mask;
        pend = pend | mask;
    endtask

    task automatic wait_batch(output int lat);
        int cnt;
        cnt = 0;
        lat = -1;
        while (pend != '0 && cnt < 3000) begin
            @(negedge clk);
            cnt++;
            if (hold_rand) hold_i = ($urandom % 4 == 0) ? N'($urandom) : '0;
            if (grant_o != '0) begin
                if (lat < 0) lat = cnt;
                pend = pend & ~grant_o;
                req_valid_i = req_valid_i & ~grant_o;
            end
        end
        if (pend != '0) begin
            checks++;
            errors++;
            $display("FAIL batch_wait: pending %b after %0d cycles, required none", pend, cnt);
            pend = '0;
            req_valid_i = '0;
            exp_grant.delete();
        end
        hold_i = '0;
    endtask

    task automatic wait_err(output bit seen);
        int cnt;
        cnt = 0;
        while (!err_timeout_o && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        seen = err_timeout_o;
        check("timeout_flag", 128'(err_timeout_o), 128'(1));
    endtask

    initial begin
        eng_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            eng_ready_i = ready_force ? 1'b1 : ($urandom % 4 != 0);
        end
    end

    // Engine model: done pulse eng_delay cycles after the start handshake; 0 = never.
    initial begin
        int d;
        eng_done_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && eng_valid_o && eng_ready_i) begin
                d = eng_delay;
                hs_cyc = cyc;
                @(posedge clk);
                if (d > 0) begin
                    repeat (d - 1) @(posedge clk);
                    @(negedge clk);
                    eng_done_i = 1'b1;
                    @(negedge clk);
                    eng_done_i = 1'b0;
                end
            end
        end
    end

    initial begin
        bit prev_pend;
        exp_t e;
        aes_key_t k;
        logic [N-1:0] expv;
        prev_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_pend = 1'b0;
            end else begin
                if (prev_pend) check("eng_valid_held", 128'(eng_valid_o), 128'(1));
                if (eng_valid_o && eng_ready_i) begin
                    if (exp_launch.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_launch: key %0h, required no launch", eng_key_o);
                    end else begin
                        k = exp_launch.pop_front();
                        check("launch_key", eng_key_o, k);
                    end
                end
                if (grant_o != '0) begin
                    if (exp_grant.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_grant: got %b, required none", grant_o);
                    end else begin
                        e = exp_grant.pop_front();
                        expv = '0;
                        expv[e.core] = 1'b1;
                        check("grant_vec", 128'(grant_o), 128'(expv));
                        check("grant_hit", 128'(grant_hit_o), 128'(e.hit));
                    end
                end
                prev_pend = eng_valid_o && !eng_ready_i;
            end
        end
    end

    initial begin
        int lat;
        bit seen;
        logic [N-1:0] mask;
        aes_key_t pool[3];
        rst = 1'b1;
        req_valid_i = '0;
        req_key_i = '0;
        hold_i = '0;
        flush_i = 1'b0;
        ready_force = 1'b1;
        hold_rand = 1'b0;
        eng_delay = 10;
        m_cv = 1'b0;
        m_ck = '0;
        m_ptr = 0;
        pend = '0;
        for (int i = 0; i < N; i++) core_key[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_grant", 128'(grant_o), 128'(0));
        check("rst_grant_hit", 128'(grant_hit_o), 128'(0));
        check("rst_eng_valid", 128'(eng_valid_o), 128'(0));
        check("rst_eng_key", eng_key_o, 128'(0));
        check("rst_busy", 128'(busy_o), 128'(0));
        check("rst_err", 128'(err_timeout_o), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // cold miss
        eng_delay = 22;
        core_key[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        start_batch(3'b001);
        wait_batch(lat);
        check("cold_miss_latency", 128'(lat), 128'(24));

        // hit from another core
        @(negedge clk);
        core_key[1] = core_key[0];
        start_batch(3'b010);
        wait_batch(lat);
        check("hit_latency", 128'(lat), 128'(1));

        // round robin with distinct keys
        ready_force = 1'b0;
        for (int r = 0; r < 4; r++) begin
            core_key[0] = rand_key();
            core_key[1] = rand_key();
            eng_delay = $urandom_range(1, 12);
            start_batch(3'b011);
            wait_batch(lat);
        end

        // hold blocks a miss until released
        @(negedge clk);
        hold_i = 3'b001;
        core_key[1] = rand_key();
        eng_delay = 5;
        start_batch(3'b010);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("hold_no_launch", 128'(eng_valid_o), 128'(0));
        end
        hold_i = '0;
        @(negedge clk);
        check("hold_release_launch", 128'(eng_valid_o), 128'(1));
        wait_batch(lat);

        // engine timeout, relaunch, then flush
        @(negedge clk);
        ready_force = 1'b1;
        eng_delay = 0;
        core_key[0] = rand_key();
        start_batch(3'b001);
        wait_err(seen);
        check("timeout_cycles", 128'(cyc - hs_cyc), 128'(WM + 2));
        exp_launch.push_back(core_key[0]);
        eng_delay = 7;
        wait_batch(lat);
        check("err_sticky", 128'(err_timeout_o), 128'(1));
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        m_cv = 1'b0;
        check("flush_clears_err", 128'(err_timeout_o), 128'(0));
        core_key[2] = core_key[0];
        start_batch(3'b100);
        wait_batch(lat);

        // reset while waiting on the engine
        @(negedge clk);
        eng_delay = 0;
        core_key[1] = rand_key();
        start_batch(3'b010);
        wait_err(seen);
        exp_launch.push_back(core_key[1]);
        repeat (6) @(negedge clk);
        check("pre_rst_busy", 128'(busy_o), 128'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_eng_valid", 128'(eng_valid_o), 128'(0));
        check("mid_rst_busy", 128'(busy_o), 128'(0));
        check("mid_rst_grant", 128'(grant_o), 128'(0));
        check("mid_rst_err", 128'(err_timeout_o), 128'(0));
        check("relaunch_seen", 128'(exp_launch.size()), 128'(0));
        exp_grant.delete();
        exp_launch.delete();
        pend = '0;
        req_valid_i = '0;
        m_cv = 1'b0;
        m_ck = '0;
        m_ptr = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        eng_delay = 9;
        @(negedge clk);
        start_batch(3'b010);
        wait_batch(lat);

        // randomized batches over a small key pool to mix hits and misses
        for (int i = 0; i < 3; i++) pool[i] = rand_key();
        ready_force = 1'b0;
        hold_rand = 1'b1;
        for (int b = 0; b < 40; b++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++)
                if (mask[i]) core_key[i] = pool[$urandom % 3];
            eng_delay = $urandom_range(1, 30);
            start_batch(mask);
            wait_batch(lat);
            if ($urandom % 5 == 0) begin
                @(negedge clk);
                flush_i = 1'b1;
                @(negedge clk);
                flush_i = 1'b0;
                m_cv = 1'b0;
            end
        end
        hold_rand = 1'b0;

        repeat (5) @(negedge clk);
        check("grants_drained", 128'(exp_grant.size()), 128'(0));
        check("launches_drained", 128'(exp_launch.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
